// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between inst fetch (owner 0) and data (owner 1), routing in-order responses back.
// Optional ARB_ROUND_ROBIN_EN: round-robin between simultaneous requesters instead of data-over-inst priority.
module sram_like_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int OID_W       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        arb_resp_err
);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic [OID_W-1:0] CNT_FULL = OID_W'(OUTSTANDING);

    logic [OUTSTANDING-1:0] fifo_q;
    logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OID_W-1:0]       count_q, count_d;
    logic                   lock_valid_q, lock_valid_d;
    logic                   lock_owner_q, lock_owner_d;
    logic                   err_q, err_d;
    logic                   sel, sel_req, full, push, pop, head;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last_q, rr_last_d;
`endif

    // Owner selection: a stalled request keeps its grant until accepted or withdrawn.
    always_comb begin
        sel = data_req;
        if (lock_valid_q) begin
            sel = lock_owner_q;
        end else if (data_req && inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            sel = ~rr_last_q;
`else
            sel = 1'b1;
`endif
        end
    end

    assign sel_req = sel ? data_req : inst_req;
    assign full    = (count_q == CNT_FULL);
    assign m_req   = !reset && !full && sel_req;
    assign push    = m_req && m_addr_ok;
    assign pop     = !reset && m_data_ok && (count_q != '0);
    assign head    = fifo_q[rptr_q];

    assign m_wr    = sel ? data_wr    : inst_wr;
    assign m_size  = sel ? data_size  : inst_size;
    assign m_addr  = sel ? data_addr  : inst_addr;
    assign m_wdata = sel ? data_wdata : inst_wdata;

    assign inst_addr_ok = push && !sel;
    assign data_addr_ok = push &&  sel;
    assign inst_data_ok = pop  && !head;
    assign data_data_ok = pop  &&  head;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign arb_resp_err = err_q;

    always_comb begin
        wptr_d       = push ? ((wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d       = pop  ? ((rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1) : rptr_q;
        count_d      = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        if (push) begin
            lock_valid_d = 1'b0;
        end else if (m_req) begin
            lock_valid_d = 1'b1;
            lock_owner_d = sel;
        end else if (lock_valid_q && !sel_req) begin
            lock_valid_d = 1'b0;
        end
        err_d        = err_q | (m_data_ok && (count_q == '0));
    end

`ifdef ARB_ROUND_ROBIN_EN
    assign rr_last_d = push ? sel : rr_last_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q    <= 1'b0;
`endif
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            err_q        <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q    <= rr_last_d;
`endif
        end
    end

    // Owner FIFO contents need no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= sel;
    end
endmodule
